// File: rtl/osc_pkg.sv
// Shared oscilloscope types: sample format, filter mode, sequencer states and
// the output clamp used by the IIR step.
package osc_pkg;

    localparam int SAMPLE_W = 12;

    typedef logic signed [SAMPLE_W-1:0] sample_t;

    typedef enum logic {
        FILT_LP = 1'b0,
        FILT_HP = 1'b1
    } filt_mode_t;

    localparam sample_t SAMPLE_MAX = 12'sd2047;
    localparam sample_t SAMPLE_MIN = -12'sd2047;

    typedef enum logic [1:0] {
        SEQ_IDLE,
        SEQ_READ,
        SEQ_DRAIN,
        SEQ_DONE
    } seq_state_t;

    // Symmetric saturation: -2048 is never emitted so the display stays balanced.
    function automatic sample_t clamp_sample(input logic signed [SAMPLE_W:0] v);
        logic signed [SAMPLE_W:0] max_w;
        logic signed [SAMPLE_W:0] min_w;
        max_w = {SAMPLE_MAX[SAMPLE_W-1], SAMPLE_MAX};
        min_w = {SAMPLE_MIN[SAMPLE_W-1], SAMPLE_MIN};
        if (v > max_w) begin
            return SAMPLE_MAX;
        end else if (v < min_w) begin
            return SAMPLE_MIN;
        end else begin
            return v[SAMPLE_W-1:0];
        end
    endfunction

endpackage

// File: rtl/filter_core.sv
// Combinational first-order IIR step: s_next = floor((x + s) / 2), output is
// the clamped low-pass state or the clamped high-pass residue x - s_next.
module filter_core
    import osc_pkg::*;
(
    input  sample_t    x,
    input  sample_t    s,
    input  filt_mode_t mode,
    output sample_t    s_next,
    output sample_t    y
);

    logic signed [SAMPLE_W:0] x_w;
    logic signed [SAMPLE_W:0] s_w;
    logic signed [SAMPLE_W:0] t_w;
    logic signed [SAMPLE_W:0] s_next_w;
    logic signed [SAMPLE_W:0] hp_w;

    always_comb begin
        x_w      = {x[SAMPLE_W-1], x};
        s_w      = {s[SAMPLE_W-1], s};
        t_w      = x_w + s_w;
        // Dropping the LSB of the 13-bit sum is the floor-halving; it always fits 12 bits.
        s_next   = t_w[SAMPLE_W:1];
        s_next_w = {s_next[SAMPLE_W-1], s_next};
        hp_w     = x_w - s_next_w;
        if (mode == FILT_HP) begin
            y = clamp_sample(hp_w);
        end else begin
            y = clamp_sample(s_next_w);
        end
    end

endmodule

// File: rtl/filter_sequencer.sv
// Walks the capture buffer through the IIR filter into the display RAM, one
// sample per clock. Define FILTER_SEQ_PEAK_EN to add peak_max/peak_min outputs.
module filter_sequencer
    import osc_pkg::*;
#(
    parameter int N_SAMPLES = 256,
    parameter int DW        = 12,
    parameter int AW        = $clog2(N_SAMPLES)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          mode,
    output logic          busy,
    output logic          done,
    output logic          rd_en,
    output logic [AW-1:0] rd_addr,
    input  logic [DW-1:0] rd_data,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
`ifdef FILTER_SEQ_PEAK_EN
    output logic [DW-1:0] wr_data,
    output logic signed [DW-1:0] peak_max,
    output logic signed [DW-1:0] peak_min
`else
    output logic [DW-1:0] wr_data
`endif
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(N_SAMPLES - 1);

    seq_state_t    state_reg;
    seq_state_t    state_next;
    filt_mode_t    mode_reg;
    logic [AW-1:0] addr_reg;
    sample_t       s_reg;
    logic          rd_valid_reg;
    logic [AW-1:0] rd_addr_d_reg;
    logic          wr_en_reg;
    logic [AW-1:0] wr_addr_reg;
    logic [DW-1:0] wr_data_reg;
    logic          accept;
    sample_t       s_next;
    sample_t       y;

    filter_core u_core (
        .x      (sample_t'(rd_data)),
        .s      (s_reg),
        .mode   (mode_reg),
        .s_next (s_next),
        .y      (y)
    );

    assign accept  = (state_reg == SEQ_IDLE) && start;
    assign rd_addr = addr_reg;
    assign wr_en   = wr_en_reg;
    assign wr_addr = wr_addr_reg;
    assign wr_data = wr_data_reg;

    always_comb begin
        state_next = state_reg;
        busy       = 1'b0;
        done       = 1'b0;
        rd_en      = 1'b0;
        case (state_reg)
            SEQ_IDLE: begin
                if (start) begin
                    state_next = SEQ_READ;
                end
            end
            SEQ_READ: begin
                busy  = 1'b1;
                rd_en = 1'b1;
                if (addr_reg == LAST_ADDR) begin
                    state_next = SEQ_DRAIN;
                end
            end
            SEQ_DRAIN: begin
                busy = 1'b1;
                // Once no read data is in flight, the final write is on the output registers.
                if (!rd_valid_reg) begin
                    state_next = SEQ_DONE;
                end
            end
            SEQ_DONE: begin
                busy       = 1'b1;
                done       = 1'b1;
                state_next = SEQ_IDLE;
            end
            default: state_next = SEQ_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= SEQ_IDLE;
            mode_reg      <= FILT_LP;
            addr_reg      <= '0;
            s_reg         <= '0;
            rd_valid_reg  <= 1'b0;
            rd_addr_d_reg <= '0;
            wr_en_reg     <= 1'b0;
            wr_addr_reg   <= '0;
            wr_data_reg   <= '0;
        end else begin
            state_reg     <= state_next;
            rd_valid_reg  <= rd_en;
            rd_addr_d_reg <= addr_reg;
            wr_en_reg     <= rd_valid_reg;
            wr_addr_reg   <= rd_addr_d_reg;
            if (accept) begin
                mode_reg <= filt_mode_t'(mode);
                addr_reg <= '0;
                s_reg    <= '0;
            end else begin
                if (state_reg == SEQ_READ) begin
                    addr_reg <= addr_reg + AW'(1);
                end
                if (rd_valid_reg) begin
                    s_reg <= s_next;
                end
            end
            if (rd_valid_reg) begin
                wr_data_reg <= DW'(y);
            end
        end
    end

`ifdef FILTER_SEQ_PEAK_EN
    logic signed [DW-1:0] peak_max_reg;
    logic signed [DW-1:0] peak_min_reg;
    logic signed [DW-1:0] wr_data_s;

    assign wr_data_s = $signed(wr_data_reg);
    assign peak_max  = peak_max_reg;
    assign peak_min  = peak_min_reg;

    // Tracks what actually reached the display RAM, so it follows the write register.
    always_ff @(posedge clk) begin
        if (rst) begin
            peak_max_reg <= '0;
            peak_min_reg <= '0;
        end else if (accept) begin
            peak_max_reg <= {1'b1, {(DW-1){1'b0}}};
            peak_min_reg <= {1'b0, {(DW-1){1'b1}}};
        end else if (wr_en_reg) begin
            if (wr_data_s > peak_max_reg) begin
                peak_max_reg <= wr_data_s;
            end
            if (wr_data_s < peak_min_reg) begin
                peak_min_reg <= wr_data_s;
            end
        end
    end
`endif

endmodule

// File: tb/tb_filter_sequencer.sv
// Directed bench for filter_sequencer: a reference IIR model fills a scoreboard
// at each start, and every display-RAM write is popped and compared.
module tb_filter_sequencer;

    localparam int N  = 256;
    localparam int DW = 12;
    localparam int AW = 8;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 start;
    logic                 mode;
    logic                 busy;
    logic                 done;
    logic                 rd_en;
    logic [AW-1:0]        rd_addr;
    logic [DW-1:0]        rd_data;
    logic                 wr_en;
    logic [AW-1:0]        wr_addr;
    logic signed [DW-1:0] wr_data;
`ifdef FILTER_SEQ_PEAK_EN
    logic signed [DW-1:0] peak_max;
    logic signed [DW-1:0] peak_min;
`endif

    filter_sequencer #(.N_SAMPLES(N), .DW(DW), .AW(AW)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .mode    (mode),
        .busy    (busy),
        .done    (done),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
`ifdef FILTER_SEQ_PEAK_EN
        .wr_data (wr_data),
        .peak_max(peak_max),
        .peak_min(peak_min)
`else
        .wr_data (wr_data)
`endif
    );

    always #5 clk = ~clk;

    logic signed [DW-1:0] mem [N];

    always @(posedge clk) begin
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

    typedef struct {
        int addr;
        int data;
    } wr_t;

    wr_t exp_q[$];
    int  checks = 0;
    int  passed = 0;
    int  fails  = 0;
    int  got[N];
    int  got_n;
    int  exp_max;
    int  exp_min;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int clampi(input int v);
        if (v > 2047) return 2047;
        if (v < -2047) return -2047;
        return v;
    endfunction

    // Reference filter over the whole buffer, starting from s = 0.
    task automatic push_expected(input bit m);
        int s;
        int x;
        int t;
        int sn;
        int y;
        s = 0;
        exp_max = -2048;
        exp_min = 2047;
        exp_q.delete();
        for (int k = 0; k < N; k++) begin
            x  = int'(mem[k]);
            t  = x + s;
            sn = t >>> 1;
            y  = m ? clampi(x - sn) : clampi(sn);
            exp_q.push_back('{k, y});
            if (y > exp_max) exp_max = y;
            if (y < exp_min) exp_min = y;
            s = sn;
        end
    endtask

    // Start is seen in cycle 0; each loop pass samples cycle c at the falling edge.
    task automatic run(input bit m, input int rst_at, input int restart_at);
        bit  live;
        bit  exp_wr;
        wr_t e;
        push_expected(m);
        got_n = 0;
        live  = 1'b1;
        start = 1'b1;
        mode  = m;
        for (int c = 1; c <= N + 6; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (c == restart_at) begin
                start = 1'b1;
                mode  = ~m;
            end
            rst = (c == rst_at);
            if (rst_at > 0 && c > rst_at) live = 1'b0;
            check($sformatf("busy c%0d", c), int'(busy), int'(live && c <= N + 3));
            check($sformatf("done c%0d", c), int'(done), int'(live && c == N + 3));
            check($sformatf("rd_en c%0d", c), int'(rd_en), int'(live && c <= N));
            if (live && c <= N) begin
                check($sformatf("rd_addr c%0d", c), int'(rd_addr), c - 1);
            end
            exp_wr = live && c >= 3 && c <= N + 2;
            check($sformatf("wr_en c%0d", c), int'(wr_en), int'(exp_wr));
            if (wr_en && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check($sformatf("wr_addr c%0d", c), int'(wr_addr), e.addr);
                check($sformatf("wr_data a%0d", e.addr), int'(wr_data), e.data);
                if (got_n < N) begin
                    got[got_n] = int'(wr_data);
                    got_n++;
                end
            end
`ifdef FILTER_SEQ_PEAK_EN
            if (live && (c == N + 3 || c == N + 6)) begin
                check($sformatf("peak_max c%0d", c), int'(peak_max), exp_max);
                check($sformatf("peak_min c%0d", c), int'(peak_min), exp_min);
            end
`endif
        end
        if (live) begin
            check("writes_missing", exp_q.size(), 0);
        end
        rst = 1'b0;
    endtask

    task automatic fill(input int v);
        for (int k = 0; k < N; k++) mem[k] = DW'(v);
    endtask

    initial begin
        int mn;
        rst   = 1'b1;
        start = 1'b0;
        mode  = 1'b0;
        repeat (3) @(negedge clk);
        check("rst busy", int'(busy), 0);
        check("rst done", int'(done), 0);
        check("rst rd_en", int'(rd_en), 0);
        check("rst rd_addr", int'(rd_addr), 0);
        check("rst wr_en", int'(wr_en), 0);
        check("rst wr_addr", int'(wr_addr), 0);
        check("rst wr_data", int'(wr_data), 0);
`ifdef FILTER_SEQ_PEAK_EN
        check("rst peak_max", int'(peak_max), 0);
        check("rst peak_min", int'(peak_min), 0);
`endif
        rst = 1'b0;
        @(negedge clk);

        fill(1000);
        run(1'b0, -1, -1);
        check("lp1000 y0", got[0], 500);
        check("lp1000 y1", got[1], 750);
        check("lp1000 y2", got[2], 875);
        check("lp1000 y3", got[3], 937);
        $display("run lp 1000: writes=%0d", got_n);

        run(1'b1, -1, -1);
        check("hp1000 y0", got[0], 500);
        check("hp1000 y1", got[1], 250);
        check("hp1000 y2", got[2], 125);
        check("hp1000 y3", got[3], 63);
        $display("run hp 1000: writes=%0d", got_n);

        fill(-2048);
        run(1'b0, -1, -1);
        check("lpneg y0", got[0], -1024);
        check("lpneg y1", got[1], -1536);
        check("lpneg ylast", got[N-1], -2047);
        mn = 0;
        for (int k = 0; k < got_n; k++) if (got[k] < mn) mn = got[k];
        check("lpneg floor", mn, -2047);
        $display("run lp -2048: writes=%0d min=%0d", got_n, mn);

        fill(1000);
        run(1'b0, -1, 10);
        check("restart y0", got[0], 500);
        check("restart y3", got[3], 937);
        $display("run lp 1000 with ignored restart: writes=%0d", got_n);

        run(1'b1, 50, -1);
        $display("run hp 1000 reset at cycle 50: writes=%0d", got_n);
        run(1'b0, -1, -1);
        check("after_rst y0", got[0], 500);
        check("after_rst y1", got[1], 750);
        check("after_rst y2", got[2], 875);
        check("after_rst y3", got[3], 937);
        $display("run lp 1000 after reset: writes=%0d", got_n);

        for (int k = 0; k < N; k++) mem[k] = (k % 2 == 0) ? DW'(2000) : DW'(-2000);
        run(1'b0, -1, -1);
        $display("run lp alternating: writes=%0d max=%0d min=%0d", got_n, exp_max, exp_min);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/filter_sequencer.md
Name: filter_sequencer

Overview:
- Controller that walks one captured sample buffer (N_SAMPLES words) through a first-order IIR filter, one sample per clock.
- Reads raw samples from the capture RAM and writes filtered samples to the display RAM.
- Sits between the ADC capture buffer and the display/trigger logic; the trigger FSM starts it after each capture completes.
- Owns filter state sequencing (y[-1]=0, in-order traversal), start/busy/done handshake and mode latching.

Parameters:
- N_SAMPLES, 256, samples per buffer; must be a power of two, at least 4.
- DW, 12, sample width (signed two's complement).
- AW, $clog2(N_SAMPLES), address width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  one-cycle request to filter the buffer.
- mode  in  1  0 = low-pass, 1 = high-pass; sampled only when start is accepted.
- busy  out  1  high from the cycle after acceptance until done, inclusive.
- done  out  1  one-cycle pulse after the last write.
- rd_en  out  1  capture RAM read strobe.
- rd_addr  out  AW  capture RAM read address.
- rd_data  in  DW  capture RAM data; valid 1 cycle after rd_en.
- wr_en  out  1  display RAM write strobe.
- wr_addr  out  AW  display RAM write address.
- wr_data  out  DW  filtered sample.

Behaviour:
- Reset: all outputs are 0; FSM is IDLE; filter state s = 0; mode latch = 0.
- FSM states: IDLE, READ, DRAIN, DONE.
  - IDLE: start=1 latches mode, clears s and the address counter, then goes to READ.
  - READ: issues rd_en=1 with rd_addr = 0..N-1 on consecutive cycles. After address N-1 it goes to DRAIN.
  - DRAIN: waits for the last write to retire, then goes to DONE.
  - DONE: done=1 and busy=1 for one cycle, then back to IDLE.
- Timing, with start seen in cycle 0:
  - rd_addr k is issued in cycle 1+k.
  - wr_en/wr_addr k/wr_data k are registered and visible in cycle 3+k.
  - done is high in cycle N+3; busy is high in cycles 1..N+3.
- start while not IDLE is ignored, and the mode change is ignored too.
- Arithmetic, per sample x (signed DW):
  - 13-bit sum t = x + s; s_next = t >>> 1 (arithmetic shift, floor).
  - LP output = clamp(s_next). HP output = clamp(x - s_next), computed in 13 bits.
  - clamp saturates to [-2047, +2047].
  - s itself is never clamped and is updated for every sample. The sample at k=0 uses s=0.
- wr_addr equals the read address delayed by 2 cycles; no gaps, no reordering.
- rst mid-operation: returns to IDLE next cycle. No done pulse; wr_en and rd_en drop immediately. The display RAM contents are left partial.
- start and rst in the same cycle: rst wins.
- start in the cycle DONE returns to IDLE: ignored. It must arrive while in IDLE.

Optional Feature:
- Macro FILTER_SEQ_PEAK_EN.
- When defined, adds outputs peak_max and peak_min (DW, signed). They track the max/min of the written wr_data over the run, are updated on every wr_en, and are initialised on acceptance to -2048 and +2047 respectively. Both are valid and stable from the done cycle until the next acceptance; reset value 0.
- When undefined, the ports and logic are absent and the remaining behaviour is identical.

Decomposition:
- Shared package osc_pkg holds:
  - typedef sample_t (signed [11:0]);
  - typedef enum filt_mode_t {FILT_LP, FILT_HP};
  - constants SAMPLE_MAX = 2047 and SAMPLE_MIN = -2047;
  - the sequencer state enum.
- One sub-module, filter_core: a purely combinational step that takes (x, s, mode) and returns (s_next, y) with the clamp. The sequencer owns all registers.

Test Plan:
- All samples = 1000, LP:
  - wr_data[0..3] = 500, 750, 875, 937.
  - wr_addr 0..255 appear contiguous in cycles 3..258.
  - done is high in cycle 259 only.
- All samples = 1000, HP: wr_data[0..3] = 500, 250, 125, 63.
- All samples = -2048, LP:
  - early outputs are -1024, -1536.
  - once s reaches -2048, outputs clamp to -2047.
  - no output is ever below -2047.
- Start pulse at cycle 10 of a run, with mode toggled: ignored. Outputs match the original mode; exactly one done pulse.
- rst asserted at cycle 50 of a run:
  - rd_en/wr_en are 0 from cycle 51.
  - there is no done pulse.
  - a new start with samples = 1000 then reproduces the first scenario, proving s was re-zeroed.
- FILTER_SEQ_PEAK_EN, samples alternating +2000/-2000, LP:
  - peak_max/peak_min equal the maximum and minimum of the written wr_data.
  - both are stable from done until the next acceptance.
